// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - stage-slot bundle carried between pipeline registers
//
// Groups every field of one pipeline slot so a stage register can take its
// upstream side and its downstream side as single ports.
//   valid     slot holds a real instruction
//   instr     instruction word (32)
//   pc, pc8   PC and PC+8 (PC_W)
//   payload   packed operands (PAYLOAD_W)
//   exc       exception code, 0 = none (EXC_W)
//   bd        instruction sits in a branch delay slot
//   badvaddr  faulting virtual address (32)
// Modports: master drives the slot, slave observes it.

interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 96,
  parameter int PC_W      = 32,
  parameter int EXC_W     = 5
);
  logic                 valid;
  logic [31:0]          instr;
  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      pc8;
  logic [PAYLOAD_W-1:0] payload;
  logic [EXC_W-1:0]     exc;
  logic                 bd;
  logic [31:0]          badvaddr;

  modport master (
    output valid, instr, pc, pc8, payload, exc, bd, badvaddr
  );

  modport slave (
    input valid, instr, pc, pc8, payload, exc, bd, badvaddr
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with exception merge
//
// Registers one pipeline slot between two stages of the core (D->E, E->M,
// M->W). The first exception in program order wins: an exception already
// carried from earlier stages beats one detected by the upstream stage.
// Update priority on posedge clk: reset > req > clr > en > hold.
//
// Ports:
//   clk             clock, rising edge
//   reset           synchronous, active-high
//   req             exception taken: load EXC_VECTOR, kill the slot
//   clr             bubble: kill the slot but keep pc/pc8/bd for EPC recovery
//   en              advance: capture the upstream slot
//   in_stage        upstream slot (slave)
//   local_exc       exception raised by the upstream stage itself
//   local_badvaddr  BadVAddr that accompanies local_exc
//   out_stage       registered slot (master)
//   stall_cnt       saturating count of cycles held with a valid slot
//   bubble_cnt      saturating count of bubbles inserted by clr
//
// Configuration: define PIPE_STAGE_PERF_CNT_EN to build the performance
// counters; otherwise stall_cnt/bubble_cnt are tied to zero.

module pipe_stage_reg #(
  parameter int              PAYLOAD_W  = 96,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = 5,
  parameter logic [PC_W-1:0] RESET_PC   = 32'hbfc00000,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'hbfc00380,
  parameter int              CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               clr,
  input  logic               en,
  pipe_stage_reg_if.slave    in_stage,
  input  logic [EXC_W-1:0]   local_exc,
  input  logic [31:0]        local_badvaddr,
  pipe_stage_reg_if.master   out_stage,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic [EXC_W-1:0] merged_exc;
  logic [31:0]      merged_badvaddr;

  // A local exception only counts for a real instruction; without any
  // exception the upstream BadVAddr is still forwarded unchanged.
  always_comb begin
    merged_exc      = '0;
    merged_badvaddr = in_stage.badvaddr;
    if (in_stage.exc != '0) begin
      merged_exc      = in_stage.exc;
      merged_badvaddr = in_stage.badvaddr;
    end else if (in_stage.valid && (local_exc != '0)) begin
      merged_exc      = local_exc;
      merged_badvaddr = local_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_stage.valid    <= 1'b0;
      out_stage.instr    <= '0;
      out_stage.pc       <= RESET_PC;
      out_stage.pc8      <= RESET_PC;
      out_stage.payload  <= '0;
      out_stage.exc      <= '0;
      out_stage.bd       <= 1'b0;
      out_stage.badvaddr <= '0;
    end else if (req) begin
      out_stage.valid    <= 1'b0;
      out_stage.instr    <= '0;
      out_stage.pc       <= EXC_VECTOR;
      out_stage.pc8      <= EXC_VECTOR;
      out_stage.payload  <= '0;
      out_stage.exc      <= '0;
      out_stage.bd       <= 1'b0;
      out_stage.badvaddr <= '0;
    end else if (clr) begin
      // Bubble keeps pc/pc8/bd so a later exception on it still has an EPC.
      out_stage.valid    <= 1'b0;
      out_stage.instr    <= '0;
      out_stage.pc       <= in_stage.pc;
      out_stage.pc8      <= in_stage.pc8;
      out_stage.payload  <= '0;
      out_stage.exc      <= '0;
      out_stage.bd       <= in_stage.bd;
      out_stage.badvaddr <= '0;
    end else if (en) begin
      out_stage.valid    <= in_stage.valid;
      out_stage.instr    <= in_stage.instr;
      out_stage.pc       <= in_stage.pc;
      out_stage.pc8      <= in_stage.pc8;
      out_stage.payload  <= in_stage.payload;
      out_stage.exc      <= merged_exc;
      out_stage.bd       <= in_stage.bd;
      out_stage.badvaddr <= merged_badvaddr;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  // Both counters stick at all-ones; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!req && !clr && !en && out_stage.valid && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!req && clr && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
